register_bank_mem: RTL and testbench
====================================

// Module: register_bank_mem
// PURPOSE
//  Parametrised multi-word register bank for the memory subsystem; generalises the single preset/reset flip-flop register.
//  Storage is a RAM-inferable array with byte-lane writes, a registered read port with valid strobe, and Tick-gated access.
//  Reset and preset are realised by a sequential init sweep (one word per clock), so the array needs no per-bit reset.
//  Replaces the tri-state chip-select output: Q is always driven, and cs only gates access.
// PARAMETERS
//  NrOfBits    32  word width; must be a multiple of 8
//  NrOfWords   16  number of words, 2..2**AddrBits
//  AddrBits    4   address width
//  WriteFirst  1   1: read of a word being written returns the new data; 0: returns the old data
// PORTS
//  Clock        in   1            single clock; all logic on its rising edge
//  Reset        in   1            synchronous, active-high; starts a zero-fill sweep
//  ClockEnable  in   1            access qualifier
//  Tick         in   1            access qualifier; access only when ClockEnable&Tick
//  pre          in   1            synchronous preset request; starts an all-ones fill sweep
//  cs           in   1            chip select, active-high
//  we           in   1            write request
//  re           in   1            read request (we and re may both be 1)
//  Addr         in   AddrBits     word address
//  Be           in   NrOfBits/8   byte-lane write enables; lane i covers D[8i+7:8i]
//  D            in   NrOfBits     write data
//  Q            out  NrOfBits     read data; holds the last read result
//  RdValid      out  1            one-cycle pulse when Q is updated
//  AddrErr      out  1            one-cycle pulse, aligned with RdValid, for an out-of-range access
//  Busy         out  1            high during a Reset or sweep; accesses are ignored
// BEHAVIOUR
//  - Reset is synchronous and active-high. While Reset=1: state=INIT, fill=0, sweep index=0, Q=0, RdValid=0, AddrErr=0, Busy=1.
//  - FSM states:
//    - IDLE -> INIT on pre=1.
//    - INIT writes fill to word[idx] on every clock, ignoring ClockEnable/Tick. idx increments.
//    - INIT -> IDLE after word NrOfWords-1 is written. Busy falls in that next cycle.
//    - A zero-fill sweep completes NrOfWords clocks after Reset deasserts.
//  - Priority: Reset > pre > access.
//    - pre during INIT restarts the sweep at idx 0 with fill=all-ones.
//    - Reset during INIT restarts the sweep with fill=0.
//  - Access accepted = cs & ClockEnable & Tick & ~Busy & ~pre & ~Reset. Requests that are not accepted are dropped; there is no queueing.
//  - Write: word[Addr] lane i <= D lane i where Be[i]=1. Be=0 is a legal no-op write.
//  - Read: latency 1. The cycle after acceptance, Q=word[Addr] and RdValid=1.
//    - Q holds otherwise.
//    - A read accepted in the cycle before pre asserts still completes.
//  - Simultaneous we&re to the same Addr:
//    - WriteFirst=1: Q = merged new word.
//    - WriteFirst=0: Q = pre-write word.
//  - Out-of-range access (Addr >= NrOfWords):
//    - Write is discarded and the array is unchanged.
//    - A read returns Q=0 with RdValid=1.
//    - Either case pulses AddrErr=1 in the cycle after acceptance.
//  - Back-to-back reads on consecutive Ticks are fully pipelined, one per clock.
// STRUCTURE
//  - Package register_bank_pkg: state enum {IDLE, INIT}, FILL_ZERO/FILL_ONES constants, and a lane-merge function merge(old, new, be).
//  - Sub-module register_bank_init_fsm: state, idx counter, fill select, Busy; outputs the sweep write port.
//  - Top level: array, write mux (sweep vs access), read register, collision bypass.
// TESTING
//  1. Reset 1 clk, then idle -> Busy=1 for exactly 16 clks after deassert. Every read then returns Q=0x00000000.
//  2. Write Addr=3 D=0xA1B2C3D4 Be=0101 over initial zeros, then read Addr 3 -> Q=0x00B200D4, RdValid 1 clk after acceptance.
//  3. we&re to Addr 5 (old 0x11111111, D=0x22222222, Be=1111): WriteFirst=1 -> Q=0x22222222; WriteFirst=0 -> Q=0x11111111.
//  4. pre mid-operation, then a read of any address after Busy falls -> Q=0xFFFFFFFF. Reset at sweep idx 7 -> full restart and a zero fill.
//  5. NrOfWords=12, write/read Addr 13 -> array unchanged, Q=0, AddrErr=RdValid=1. Access with Tick=0 or cs=0 -> no effect.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the register bank.
//   state_t     : init-sweep FSM states (IDLE, INIT)
//   FILL_ZERO / FILL_ONES : fill-pattern select bit replicated across a word
//   merge()     : byte-lane merge of a new word into an old word
package register_bank_pkg;

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_ONES = 1'b1;

  // merge() works on a fixed maximum width so one function serves every
  // word size; callers zero-extend the operands and truncate the result.
  localparam int MAX_BITS  = 1024;
  localparam int MAX_BYTES = MAX_BITS / 8;

  function automatic logic [MAX_BITS-1:0] merge(input logic [MAX_BITS-1:0]  old_w,
                                                input logic [MAX_BITS-1:0]  new_w,
                                                input logic [MAX_BYTES-1:0] be);
    logic [MAX_BITS-1:0] r;
    for (int i = 0; i < MAX_BYTES; i++)
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/register_bank_init_fsm.sv
// Init-sweep controller: after Reset or pre, walks every word once (one per
// clock) and drives a write port that fills it with zeros or ones.
//   Clock, Reset, pre : clock, sync active-high reset, sync preset request
//   Busy              : high while Reset is held or a sweep is in progress
//   sweep_we/addr/data: sweep write port into the storage array
module register_bank_init_fsm
  import register_bank_pkg::*;
#(
  parameter int NrOfBits  = 32,
  parameter int NrOfWords = 16,
  parameter int AddrBits  = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  output logic                Busy,
  output logic                sweep_we,
  output logic [AddrBits-1:0] sweep_addr,
  output logic [NrOfBits-1:0] sweep_data
);

  localparam logic [AddrBits-1:0] LAST = AddrBits'(NrOfWords - 1);

  state_t              state, state_nx;
  logic [AddrBits-1:0] idx, idx_nx;
  logic                fill, fill_nx;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= INIT;
      idx   <= '0;
      fill  <= FILL_ZERO;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      fill  <= fill_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    fill_nx  = fill;
    if (pre) begin
      // A preset always (re)starts a full ones sweep, even mid-sweep.
      state_nx = INIT;
      idx_nx   = '0;
      fill_nx  = FILL_ONES;
    end else if (state == INIT) begin
      if (idx == LAST) begin
        state_nx = IDLE;
        idx_nx   = '0;
      end else begin
        idx_nx = idx + 1'b1;
      end
    end
  end

  // The cycle carrying Reset or pre only rearms the sweep; writing starts
  // on the following clock at idx 0.
  assign Busy       = (state == INIT) | Reset;
  assign sweep_we   = (state == INIT) & ~Reset & ~pre;
  assign sweep_addr = idx;
  assign sweep_data = {NrOfBits{fill}};

endmodule

// File: rtl/register_bank_mem.sv
// Multi-word register bank with byte-lane writes and a registered read port.
// Reset/preset are applied by a one-word-per-clock sweep, so the array itself
// carries no reset and can map onto RAM.
//   Clock, Reset        : clock, sync active-high reset (starts zero sweep)
//   ClockEnable, Tick   : both must be high for an access
//   pre                 : sync preset (starts ones sweep)
//   cs, we, re          : chip select, write and read requests
//   Addr, Be, D         : word address, byte-lane enables, write data
//   Q, RdValid          : read data (held) and its one-cycle update strobe
//   AddrErr             : one-cycle pulse for an out-of-range access
//   Busy                : sweep in progress; accesses are dropped
module register_bank_mem
  import register_bank_pkg::*;
#(
  parameter int NrOfBits   = 32,
  parameter int NrOfWords  = 16,
  parameter int AddrBits   = 4,
  parameter bit WriteFirst = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ClockEnable,
  input  logic                  Tick,
  input  logic                  pre,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  re,
  input  logic [AddrBits-1:0]   Addr,
  input  logic [NrOfBits/8-1:0] Be,
  input  logic [NrOfBits-1:0]   D,
  output logic [NrOfBits-1:0]   Q,
  output logic                  RdValid,
  output logic                  AddrErr,
  output logic                  Busy
);

  logic [NrOfBits-1:0] mem [NrOfWords];

  logic                sweep_we;
  logic [AddrBits-1:0] sweep_addr;
  logic [NrOfBits-1:0] sweep_data;

  register_bank_init_fsm #(
    .NrOfBits (NrOfBits),
    .NrOfWords(NrOfWords),
    .AddrBits (AddrBits)
  ) u_init (
    .Clock     (Clock),
    .Reset     (Reset),
    .pre       (pre),
    .Busy      (Busy),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr),
    .sweep_data(sweep_data)
  );

  logic                acc;
  logic                in_range;
  logic [NrOfBits-1:0] rd_old;
  logic [NrOfBits-1:0] merged;

  // Busy already covers Reset, but Reset is kept explicit so acceptance
  // does not depend on the FSM's output decode.
  assign acc      = cs & ClockEnable & Tick & ~Busy & ~pre & ~Reset;
  assign in_range = (32'(Addr) < NrOfWords);
  assign rd_old   = mem[Addr];
  assign merged   = NrOfBits'(merge(MAX_BITS'(rd_old), MAX_BITS'(D), MAX_BYTES'(Be)));

  // Storage: sweep and access never overlap (access requires ~Busy).
  always_ff @(posedge Clock) begin
    if (sweep_we)
      mem[sweep_addr] <= sweep_data;
    else if (acc && we && in_range)
      mem[Addr] <= merged;
  end

  // Read register. rd_old is the pre-edge word, so a same-cycle write is
  // only visible when WriteFirst selects the merged bypass.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q       <= '0;
      RdValid <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      RdValid <= acc & re;
      AddrErr <= acc & (we | re) & ~in_range;
      if (acc && re) begin
        if (!in_range)
          Q <= '0;
        else if (we && WriteFirst)
          Q <= merged;
        else
          Q <= rd_old;
      end
    end
  end

endmodule

// File: tb/tb_register_bank_mem.sv
module tb_register_bank_mem;

  logic        clk = 1'b0;
  logic        Reset, ClockEnable, Tick, pre, cs, we, re;
  logic [3:0]  Addr, Be;
  logic [31:0] D;
  logic [31:0] q [3];
  logic        rv [3], ae [3], busy [3];

  always #5 clk = ~clk;

  // Instance 0: default; 1: read-first; 2: 12 words (out-of-range addresses).
  register_bank_mem #(.NrOfBits(32), .NrOfWords(16), .AddrBits(4), .WriteFirst(1'b1)) dut_a (
    .Clock(clk), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick), .pre(pre),
    .cs(cs), .we(we), .re(re), .Addr(Addr), .Be(Be), .D(D),
    .Q(q[0]), .RdValid(rv[0]), .AddrErr(ae[0]), .Busy(busy[0]));
  register_bank_mem #(.NrOfBits(32), .NrOfWords(16), .AddrBits(4), .WriteFirst(1'b0)) dut_b (
    .Clock(clk), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick), .pre(pre),
    .cs(cs), .we(we), .re(re), .Addr(Addr), .Be(Be), .D(D),
    .Q(q[1]), .RdValid(rv[1]), .AddrErr(ae[1]), .Busy(busy[1]));
  register_bank_mem #(.NrOfBits(32), .NrOfWords(12), .AddrBits(4), .WriteFirst(1'b1)) dut_c (
    .Clock(clk), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick), .pre(pre),
    .cs(cs), .we(we), .re(re), .Addr(Addr), .Be(Be), .D(D),
    .Q(q[2]), .RdValid(rv[2]), .AddrErr(ae[2]), .Busy(busy[2]));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int nw(input int k);
    return (k == 2) ? 12 : 16;
  endfunction
  function automatic bit wf(input int k);
    return (k != 1);
  endfunction
  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Reference model: a fill simply sets the whole array (nothing can observe
  // it mid-sweep) and arms a busy countdown of NrOfWords clocks.
  logic [31:0] m_mem [3][16];
  logic [31:0] m_q [3];
  bit          m_rv [3], m_ae [3];
  int          m_busy [3];
  bit          started = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (Reset) begin
        for (int w = 0; w < 16; w++) m_mem[k][w] = 32'h0;
        m_busy[k] = nw(k);
        m_q[k] = 32'h0; m_rv[k] = 0; m_ae[k] = 0;
      end else begin
        bit acc, oor;
        logic [31:0] old;
        acc = cs && ClockEnable && Tick && !pre && (m_busy[k] == 0);
        oor = (int'(Addr) >= nw(k));
        old = oor ? 32'h0 : m_mem[k][Addr];
        m_rv[k] = acc && re;
        m_ae[k] = acc && (we || re) && oor;
        if (acc && re) m_q[k] = oor ? 32'h0 : ((we && wf(k)) ? lane_merge(old, D, Be) : old);
        if (acc && we && !oor) m_mem[k][Addr] = lane_merge(old, D, Be);
        if (pre) begin
          for (int w = 0; w < 16; w++) m_mem[k][w] = 32'hFFFF_FFFF;
          m_busy[k] = nw(k);
        end else if (m_busy[k] > 0) begin
          m_busy[k] = m_busy[k] - 1;
        end
      end
    end
    if (Reset) started = 1'b1;
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_busy;
        exp_busy = (m_busy[k] > 0) || Reset;
        n_cmp += 4;
        if (q[k] !== m_q[k]) begin
          n_bad++; $display("FAIL model_Q[%0d] t=%0t got %h want %h", k, $time, q[k], m_q[k]);
        end
        if (rv[k] !== m_rv[k]) begin
          n_bad++; $display("FAIL model_RdValid[%0d] t=%0t got %b want %b", k, $time, rv[k], m_rv[k]);
        end
        if (ae[k] !== m_ae[k]) begin
          n_bad++; $display("FAIL model_AddrErr[%0d] t=%0t got %b want %b", k, $time, ae[k], m_ae[k]);
        end
        if (busy[k] !== exp_busy) begin
          n_bad++; $display("FAIL model_Busy[%0d] t=%0t got %b want %b", k, $time, busy[k], exp_busy);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic acc_set(input logic w, input logic r, input logic [3:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    cs = 1; ClockEnable = 1; Tick = 1; we = w; re = r; Addr = a; Be = b; D = d;
  endtask

  task automatic idle_in();
    cs = 0; we = 0; re = 0; pre = 0; Reset = 0;
  endtask

  // Counts clocks with Busy high on instance 0, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy[0] && cnt < 40) begin cnt++; step(); end
    if (busy[0]) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle timeout busy still %b", busy[0]);
    end
  endtask

  initial begin
    int cnt;
    Reset = 1; ClockEnable = 0; Tick = 0; pre = 0; cs = 0; we = 0; re = 0;
    Addr = 0; Be = 0; D = 0;
    step();
    chk("reset_Q", q[0], 32'h0);
    chk("reset_RdValid", 32'(rv[0]), 32'h0);
    chk("reset_Busy", 32'(busy[0]), 32'h1);
    Reset = 0;
    wait_idle(cnt);
    chk("zero_sweep_busy_clks", cnt, 16);

    acc_set(0, 1, 4'd7, 4'h0, 32'h0); step();
    chk("after_reset_read_Q", q[0], 32'h0);
    chk("after_reset_read_RdValid", 32'(rv[0]), 32'h1);

    // Partial-lane write, then read back.
    acc_set(1, 0, 4'd3, 4'b0101, 32'hA1B2_C3D4); step();
    chk("write_no_RdValid", 32'(rv[0]), 32'h0);
    acc_set(0, 1, 4'd3, 4'h0, 32'h0); step();
    chk("lane_write_Q", q[0], 32'h00B2_00D4);
    chk("lane_write_RdValid", 32'(rv[0]), 32'h1);
    idle_in(); step();
    chk("RdValid_one_pulse", 32'(rv[0]), 32'h0);
    chk("Q_holds", q[0], 32'h00B2_00D4);

    // Same-address write+read collision.
    acc_set(1, 0, 4'd5, 4'hF, 32'h1111_1111); step();
    acc_set(1, 1, 4'd5, 4'hF, 32'h2222_2222); step();
    chk("collision_write_first", q[0], 32'h2222_2222);
    chk("collision_read_first", q[1], 32'h1111_1111);

    // Dropped accesses: Tick low, then cs low.
    acc_set(1, 0, 4'd3, 4'hF, 32'hFFFF_FFFF); Tick = 0; step();
    acc_set(1, 0, 4'd3, 4'hF, 32'hFFFF_FFFF); cs = 0; step();
    acc_set(0, 1, 4'd3, 4'h0, 32'h0); step();
    chk("gated_access_no_effect", q[0], 32'h00B2_00D4);

    // Out-of-range on the 12-word instance.
    acc_set(1, 0, 4'd13, 4'hF, 32'hDEAD_BEEF); step();
    chk("oor_write_AddrErr", 32'(ae[2]), 32'h1);
    chk("oor_write_no_RdValid", 32'(rv[2]), 32'h0);
    acc_set(0, 1, 4'd13, 4'h0, 32'h0); step();
    chk("oor_read_Q", q[2], 32'h0);
    chk("oor_read_RdValid", 32'(rv[2]), 32'h1);
    chk("oor_read_AddrErr", 32'(ae[2]), 32'h1);
    chk("inrange_no_AddrErr", 32'(ae[0]), 32'h0);

    // Preset sweep.
    idle_in(); pre = 1; step(); pre = 0;
    wait_idle(cnt);
    chk("ones_sweep_busy_clks", cnt, 16);
    acc_set(0, 1, 4'd9, 4'h0, 32'h0); step();
    chk("preset_read_Q", q[0], 32'hFFFF_FFFF);

    // Reset at sweep index 7 of a ones sweep.
    idle_in(); pre = 1; step(); pre = 0;
    repeat (7) step();
    Reset = 1; step(); Reset = 0;
    wait_idle(cnt);
    chk("restart_busy_clks", cnt, 16);
    acc_set(0, 1, 4'd2, 4'h0, 32'h0); step();
    chk("restart_zero_low_idx", q[0], 32'h0);
    acc_set(0, 1, 4'd12, 4'h0, 32'h0); step();
    chk("restart_zero_high_idx", q[0], 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 299) == 0);
      pre         = ($urandom_range(0, 149) == 0);
      cs          = ($urandom_range(0, 7) != 0);
      ClockEnable = ($urandom_range(0, 9) != 0);
      Tick        = ($urandom_range(0, 3) != 0);
      we          = $urandom_range(0, 1);
      re          = $urandom_range(0, 1);
      Addr        = 4'($urandom_range(0, 15));
      Be          = 4'($urandom);
      D           = $urandom;
      step();
    end
    idle_in(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
